vote_request_arbiter: RTL and testbench
=======================================

// Module: vote_request_arbiter
// PURPOSE
//  Front-end controller for the voting machine datapath. Sits between the four raw
//  candidate buttons and the per-candidate vote counters. Qualifies a press by hold
//  time and rejects simultaneous presses. Issues exactly one vote pulse per accepted
//  press, and blocks voting while mode=1 (result display). Keeps a saturating count
//  of accepted votes.
// PARAMETERS
//  HOLD_CYCLES     10   consecutive cycles one button must be seen before a vote issues (>=2)
//  LOCKOUT_CYCLES  16   post-vote dead time, used only with VOTE_LOCKOUT_EN (>=1)
//  CNT_W           8    width of hold/lockout counter; must hold max(HOLD,LOCKOUT)
// PORTS
//  clk          in   1  system clock, all logic on rising edge
//  reset        in   1  synchronous, active-high reset
//  mode         in   1  0 = voting, 1 = result display (votes inhibited)
//  button       in   4  candidate buttons [0]=cand1..[3]=cand4, pre-synchronised
//  vote_valid   out  1  one-cycle pulse: accepted vote
//  vote_sel     out  2  candidate index, valid while vote_valid=1 (else holds last)
//  reject       out  1  one-cycle pulse: multi-button press detected
//  busy         out  1  1 in any state other than IDLE
//  total_votes  out  8  accepted-vote count, saturates at 255
//  state_dbg    out  3  current FSM state encoding (debug)
// BEHAVIOUR
//  - Reset (sampled at edge): state=IDLE; vote_valid=0, vote_sel=0, reject=0, busy=0,
//    total_votes=0, counter=0. Reset mid-press aborts with no vote; a held button
//    after reset deasserts is treated as a fresh press.
//  - States: IDLE=0, QUALIFY=1, ISSUE=2, RELEASE=3, REJECT=4, LOCKOUT=5 (macro only).
//  - IDLE: mode=1 -> stay. Exactly one button high -> QUALIFY, latch index, cnt<=1.
//    >=2 buttons high -> REJECT. None -> stay.
//  - QUALIFY, checked in this priority order:
//    1. mode=1 -> RELEASE (abort, no vote).
//    2. button==0 -> IDLE (glitch, no vote).
//    3. button != latched one-hot -> REJECT.
//    4. Otherwise, cnt==HOLD_CYCLES-1 -> ISSUE, else cnt++.
//  - Latency: vote_valid is high for exactly the one cycle after the HOLD_CYCLES-th
//    consecutive rising edge sampling the same single button.
//  - ISSUE (1 cycle): vote_valid=1, vote_sel=latched index. total_votes++ unless
//    already 255. Always -> RELEASE.
//  - RELEASE: wait for button==0, then -> IDLE (or LOCKOUT with macro). Holding or
//    adding buttons here is ignored: no second vote, no reject.
//  - REJECT: reject=1 only in the cycle after entry. Wait for button==0, then -> IDLE.
//  - mode changes in ISSUE/RELEASE/REJECT do not alter the sequence.
//  - Outputs vote_valid, reject, busy are registered (Moore); no combinational
//    input->output path.
// CONFIGURATION
//  VOTE_LOCKOUT_EN defined:
//    - RELEASE with button==0 -> LOCKOUT, cnt<=0.
//    - LOCKOUT ignores all buttons and mode. Returns to IDLE after LOCKOUT_CYCLES
//      cycles in LOCKOUT; busy=1 throughout.
//  VOTE_LOCKOUT_EN undefined:
//    - RELEASE -> IDLE directly.
//    - LOCKOUT state, LOCKOUT_CYCLES and its logic are absent; encoding 5 never occurs.
// TESTING (10 ns clock, HOLD_CYCLES=10)
//  1. Reset 20 cycles, then button=4'b0100 held 200 ns
//     -> one vote_valid pulse, vote_sel=2, total_votes=1, no reject.
//  2. button=4'b0001 held 5 cycles then released
//     -> no vote_valid, state back to IDLE, total_votes unchanged.
//  3. button=4'b0110 together, held 200 ns
//     -> one reject pulse, no vote, busy until release.
//  4. button=4'b0010 held 3 cycles, then 4'b1010
//     -> reject pulse, no vote. Separately, mode=1 with button=4'b0001 for 200 ns
//     -> no vote, busy=0.
//  5. Press 4'b1000, assert reset at QUALIFY cycle 5 for 1 cycle, keep button held
//     -> all outputs 0, then a vote issues 10 edges after reset deasserts.
//  6. Force 256 accepted votes -> total_votes stays 255. With VOTE_LOCKOUT_EN, a press
//     within LOCKOUT_CYCLES of release -> no vote; a press after that window -> vote.

Source files
------------

// File: rtl/vote_request_arbiter.sv
// Button qualification / vote issue controller: hold-time debounce, multi-press reject,
// one vote pulse per press, saturating vote total. Optional post-vote dead time via VOTE_LOCKOUT_EN.
module vote_request_arbiter #(
  parameter int HOLD_CYCLES    = 10,
`ifdef VOTE_LOCKOUT_EN
  parameter int LOCKOUT_CYCLES = 16,
`endif
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic [3:0] button,
  output logic       vote_valid,
  output logic [1:0] vote_sel,
  output logic       reject,
  output logic       busy,
  output logic [7:0] total_votes,
  output logic [2:0] state_dbg
);

`ifdef VOTE_LOCKOUT_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_QUALIFY = 3'd1, S_ISSUE = 3'd2,
    S_RELEASE = 3'd3, S_REJECT = 3'd4, S_LOCKOUT = 3'd5
  } state_t;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_QUALIFY = 3'd1, S_ISSUE = 3'd2,
    S_RELEASE = 3'd3, S_REJECT = 3'd4
  } state_t;
`endif

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  function automatic logic [2:0] ones(input logic [3:0] b);
    return 3'(b[0]) + 3'(b[1]) + 3'(b[2]) + 3'(b[3]);
  endfunction

  function automatic logic [1:0] enc(input logic [3:0] b);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++)
      if (b[i]) r = 2'(i);
    return r;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             vote_valid_q, vote_valid_d;
  logic [1:0]       vote_sel_q, vote_sel_d;
  logic             reject_q, reject_d;
  logic             busy_q, busy_d;
  logic [7:0]       total_q, total_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    vote_valid_d = 1'b0;
    vote_sel_d   = vote_sel_q;
    reject_d     = 1'b0;
    total_d      = total_q;

    case (state_q)
      S_IDLE: begin
        if (!mode) begin
          if (ones(button) == 3'd1) begin
            state_d = S_QUALIFY;
            idx_d   = enc(button);
            cnt_d   = CNT_W'(1);
          end else if (ones(button) >= 3'd2) begin
            state_d = S_REJECT;
          end
        end
      end
      S_QUALIFY: begin
        if (mode)                                state_d = S_RELEASE;
        else if (button == 4'b0000)              state_d = S_IDLE;
        else if (button != (4'b0001 << idx_q))   state_d = S_REJECT;
        else if (cnt_q == HOLD_LAST)             state_d = S_ISSUE;
        else                                     cnt_d   = cnt_q + CNT_W'(1);
      end
      S_ISSUE: state_d = S_RELEASE;
      S_RELEASE: begin
        if (button == 4'b0000) begin
`ifdef VOTE_LOCKOUT_EN
          state_d = S_LOCKOUT;
          cnt_d   = '0;
`else
          state_d = S_IDLE;
`endif
        end
      end
      S_REJECT: begin
        if (button == 4'b0000) state_d = S_IDLE;
      end
`ifdef VOTE_LOCKOUT_EN
      S_LOCKOUT: begin
        if (cnt_q == LOCK_LAST) state_d = S_IDLE;
        else                    cnt_d   = cnt_q + CNT_W'(1);
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    if (state_d == S_ISSUE) begin
      vote_valid_d = 1'b1;
      vote_sel_d   = idx_q;
      total_d      = sat_inc(total_q);
    end
    reject_d = (state_d == S_REJECT) && (state_q != S_REJECT);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      vote_valid_q <= 1'b0;
      vote_sel_q   <= 2'd0;
      reject_q     <= 1'b0;
      busy_q       <= 1'b0;
      total_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      vote_valid_q <= vote_valid_d;
      vote_sel_q   <= vote_sel_d;
      reject_q     <= reject_d;
      busy_q       <= busy_d;
      total_q      <= total_d;
    end
  end

  assign vote_valid  = vote_valid_q;
  assign vote_sel    = vote_sel_q;
  assign reject      = reject_q;
  assign busy        = busy_q;
  assign total_votes = total_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_vote_request_arbiter.sv
// Self-checking bench for vote_request_arbiter: directed scenarios plus randomized presses,
// all outputs compared each cycle against a press-level behavioural model.
module tb_vote_request_arbiter;
  localparam int HOLD = 10;
`ifdef VOTE_LOCKOUT_EN
  localparam int LOCK = 16;
`endif

  logic       clk, reset, mode;
  logic [3:0] button;
  logic       vote_valid, reject, busy;
  logic [1:0] vote_sel;
  logic [7:0] total_votes;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int dv, dr;

  vote_request_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .mode(mode), .button(button),
    .vote_valid(vote_valid), .vote_sel(vote_sel), .reject(reject),
    .busy(busy), .total_votes(total_votes), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase of the current press and how many edges it has been seen.
  int         m_phase;  // 0 idle,1 qualify,2 issue,3 release,4 reject,5 lockout
  int         m_run, m_lock_left, m_idx, m_total;
  int         e_valid, e_sel, e_rej;
  bit         m_init = 0;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_phase = 0; m_run = 0; m_idx = 0; m_total = 0; m_lock_left = 0;
      e_valid = 0; e_sel = 0; e_rej = 0; m_init = 1;
    end else if (m_init) begin
      e_valid = 0; e_rej = 0;
      case (m_phase)
        0: if (!mode) begin
             if ($countones(button) == 1) begin
               m_phase = 1; m_run = 1;
               for (int i = 0; i < 4; i++) if (button[i]) m_idx = i;
             end else if ($countones(button) > 1) begin
               m_phase = 4; e_rej = 1;
             end
           end
        1: if (mode) m_phase = 3;
           else if (button == 0) m_phase = 0;
           else if (button != (4'b0001 << m_idx)) begin m_phase = 4; e_rej = 1; end
           else begin
             m_run++;
             if (m_run == HOLD) begin
               m_phase = 2; e_valid = 1; e_sel = m_idx;
               if (m_total < 255) m_total++;
             end
           end
        2: m_phase = 3;
        3: if (button == 0) begin
`ifdef VOTE_LOCKOUT_EN
             m_phase = 5; m_lock_left = LOCK;
`else
             m_phase = 0;
`endif
           end
        4: if (button == 0) m_phase = 0;
        5: begin m_lock_left--; if (m_lock_left == 0) m_phase = 0; end
        default: m_phase = 0;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_init) begin
      chk("m_vote_valid", int'(vote_valid), e_valid);
      chk("m_vote_sel", int'(vote_sel), e_sel);
      chk("m_reject", int'(reject), e_rej);
      chk("m_busy", int'(busy), (m_phase != 0) ? 1 : 0);
      chk("m_total", int'(total_votes), m_total);
      chk("m_state", int'(state_dbg), m_phase);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (vote_valid) dv++;
      if (reject) dr++;
    end
  endtask

  int len, r;
  logic [3:0] pat;

  initial begin
    reset = 1'b1; mode = 1'b0; button = 4'b0000;
    dv = 0; dr = 0;
    step(20);
    chk("rst_vote_valid", int'(vote_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_total", int'(total_votes), 0);
    chk("rst_state", int'(state_dbg), 0);
    reset = 1'b0;
    step(1);

    // 1: single press held 200 ns
    dv = 0; dr = 0; button = 4'b0100;
    step(9);
    chk("s1_not_early", int'(vote_valid), 0);
    step(1);
    chk("s1_valid_at_10", int'(vote_valid), 1);
    chk("s1_sel", int'(vote_sel), 2);
    chk("s1_total", int'(total_votes), 1);
    step(10);
    button = 4'b0000;
    step(3);
    chk("s1_one_vote", dv, 1);
    chk("s1_no_reject", dr, 0);
    chk("s1_idle", int'(state_dbg), 0);

    // 2: short press
    dv = 0; dr = 0; button = 4'b0001;
    step(5);
    button = 4'b0000;
    step(3);
    chk("s2_no_vote", dv, 0);
    chk("s2_idle", int'(state_dbg), 0);
    chk("s2_total", int'(total_votes), 1);

    // 3: simultaneous press
    dv = 0; dr = 0; button = 4'b0110;
    step(20);
    chk("s3_reject", dr, 1);
    chk("s3_no_vote", dv, 0);
    chk("s3_busy", int'(busy), 1);
    button = 4'b0000;
    step(2);
    chk("s3_busy_clear", int'(busy), 0);

    // 4a: second button joins mid-qualify
    dv = 0; dr = 0; button = 4'b0010;
    step(3);
    button = 4'b1010;
    step(3);
    chk("s4_reject", dr, 1);
    chk("s4_no_vote", dv, 0);
    button = 4'b0000;
    step(2);

    // 4b: result-display mode blocks voting
    dv = 0; dr = 0; mode = 1'b1; button = 4'b0001;
    step(20);
    chk("s4b_no_vote", dv, 0);
    chk("s4b_busy", int'(busy), 0);
    button = 4'b0000; mode = 1'b0;
    step(2);

    // 5: reset mid-qualify, button kept held
    dv = 0; button = 4'b1000;
    step(5);
    reset = 1'b1;
    step(1);
    chk("s5_rst_valid", int'(vote_valid), 0);
    chk("s5_rst_busy", int'(busy), 0);
    chk("s5_rst_total", int'(total_votes), 0);
    chk("s5_rst_state", int'(state_dbg), 0);
    reset = 1'b0; dv = 0;
    step(9);
    chk("s5_not_early", dv, 0);
    step(1);
    chk("s5_valid", int'(vote_valid), 1);
    chk("s5_sel", int'(vote_sel), 3);
    chk("s5_total", int'(total_votes), 1);
    button = 4'b0000;
    step(3);

    // 6: saturation
    for (int i = 0; i < 256; i++) begin
      button = 4'b0001 << (i % 4);
      step(HOLD + 1);
      button = 4'b0000;
`ifdef VOTE_LOCKOUT_EN
      step(LOCK + 2);
`else
      step(2);
`endif
    end
    chk("s6_saturated", int'(total_votes), 255);

`ifdef VOTE_LOCKOUT_EN
    // lockout window swallows an early press
    reset = 1'b1; step(1); reset = 1'b0;
    dv = 0; button = 4'b0001;
    step(HOLD + 1);
    button = 4'b0000;
    step(3);
    button = 4'b0010;
    step(5);
    button = 4'b0000;
    step(LOCK + 2);
    chk("lk_blocked", dv, 1);
    button = 4'b0010;
    step(HOLD + 2);
    button = 4'b0000;
    step(2);
    chk("lk_after_window", dv, 2);
`endif

    // randomized presses, checked by the model each cycle
    reset = 1'b1; step(2); reset = 1'b0;
    for (int s = 0; s < 300; s++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      pat = 4'b0001 << $urandom_range(0, 3);
      else if (r < 75) pat = 4'b0000;
      else             pat = 4'($urandom_range(0, 15));
      button = pat;
      mode = ($urandom_range(0, 9) == 0);
      len = (r < 55) ? $urandom_range(1, 16) : $urandom_range(1, 6);
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1; step(1); reset = 1'b0;
      end
      step(len);
    end
    button = 4'b0000; mode = 1'b0;
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
